// File: rtl/alu_seq_pkg.sv
// Shared types for the sequential execute-stage ALU: operator encoding, FU payload,
// FSM state and bit-count sub-operation.
package alu_seq_pkg;

   localparam int unsigned RV_XLEN       = 64;
   localparam int unsigned TRANS_ID_BITS = 3;

   typedef enum logic [7:0] {
      ADD, SUB, ADDW, SUBW,
      XORL, ORL, ANDL,
      SRA, SRL, SLL, SRAW, SRLW, SLLW,
      LTS, LTU, GES, GEU, EQ, NE,
      SLTS, SLTU,
      CPOP, CPOPW, CLZ, CLZW, CTZ, CTZW,
      ROL, ROLW, ROR, RORW,
      DEBUG1, DEBUG2
   } fu_op_e;

   typedef struct packed {
      fu_op_e                    operation;
      logic [RV_XLEN-1:0]        operand_a;
      logic [RV_XLEN-1:0]        operand_b;
      logic [RV_XLEN-1:0]        imm;
      logic [TRANS_ID_BITS-1:0]  trans_id;
   } fu_data_t;

   typedef enum logic [1:0] {StIdle, StIter, StBufWait, StDrain} alu_seq_state_e;

   typedef enum logic [1:0] {CntPop, CntLz, CntTz} cnt_op_e;

   localparam logic [RV_XLEN-1:0] BUF_TIMEOUT_ALL_ONES = '1;

endpackage

// File: rtl/alu_bitcount.sv
// Iterative population count / leading-zero / trailing-zero unit.
// Fixed latency: examines CNT_STEP bits per cycle over the whole (or 32-bit) operand.
module alu_bitcount
   import alu_seq_pkg::*;
#(
   parameter int unsigned XLEN     = RV_XLEN,
   parameter int unsigned CNT_STEP = 8,
   localparam int unsigned CntW    = $clog2(XLEN + 1)
) (
   input  logic            clk_i,
   input  logic            rst_ni,
   input  logic            start_i,
   input  cnt_op_e         op_i,
   input  logic            word_i,
   input  logic [XLEN-1:0] operand_i,
   output logic            done_o,
   output logic [CntW-1:0] count_o
);

   localparam int unsigned StepW = $clog2(XLEN / CNT_STEP + 1);

   logic [XLEN-1:0]     opnd_q, opnd_d, low32;
   logic [CntW-1:0]     cnt_q, cnt_d, contrib;
   logic [StepW-1:0]    step_q, step_d, last_q, last_d;
   logic                busy_q, busy_d, found_q, found_d;
   cnt_op_e             op_q, op_d;
   logic [CNT_STEP-1:0] chunk;

   // CLZ walks from the MSB end, CPOP/CTZ from the LSB end
   always_comb begin
      chunk   = (op_q == CntLz) ? opnd_q[XLEN-1 -: CNT_STEP] : opnd_q[CNT_STEP-1:0];
      contrib = '0;
      case (op_q)
         CntPop: begin
            for (int i = 0; i < int'(CNT_STEP); i++) contrib = contrib + CntW'(chunk[i]);
         end
         CntLz: begin
            contrib = CntW'(CNT_STEP);
            for (int i = 0; i < int'(CNT_STEP); i++) begin
               if (chunk[i]) contrib = CntW'(int'(CNT_STEP) - 1 - i);
            end
         end
         CntTz: begin
            contrib = CntW'(CNT_STEP);
            for (int i = int'(CNT_STEP) - 1; i >= 0; i--) begin
               if (chunk[i]) contrib = CntW'(i);
            end
         end
         default: contrib = '0;
      endcase
      // Once the first set bit is seen, CLZ/CTZ stop accumulating but latency stays fixed
      if (op_q != CntPop && found_q) contrib = '0;
      done_o  = busy_q && (step_q == last_q);
      count_o = cnt_q + contrib;
   end

   always_comb begin
      opnd_d  = opnd_q;
      cnt_d   = cnt_q;
      step_d  = step_q;
      last_d  = last_q;
      busy_d  = busy_q;
      found_d = found_q;
      op_d    = op_q;
      low32   = XLEN'(operand_i[31:0]);
      if (busy_q) begin
         opnd_d  = (op_q == CntLz) ? (opnd_q << CNT_STEP) : (opnd_q >> CNT_STEP);
         cnt_d   = count_o;
         found_d = found_q | (|chunk);
         step_d  = step_q + 1'b1;
         if (done_o) busy_d = 1'b0;
      end
      if (start_i) begin
         op_d    = op_i;
         busy_d  = 1'b1;
         step_d  = '0;
         cnt_d   = '0;
         found_d = 1'b0;
         last_d  = word_i ? StepW'(32 / CNT_STEP - 1) : StepW'(XLEN / CNT_STEP - 1);
         if (!word_i)             opnd_d = operand_i;
         else if (op_i == CntLz)  opnd_d = low32 << (XLEN - 32);
         else                     opnd_d = low32;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         opnd_q  <= '0;
         cnt_q   <= '0;
         step_q  <= '0;
         last_q  <= '0;
         busy_q  <= 1'b0;
         found_q <= 1'b0;
         op_q    <= CntPop;
      end else begin
         opnd_q  <= opnd_d;
         cnt_q   <= cnt_d;
         step_q  <= step_d;
         last_q  <= last_d;
         busy_q  <= busy_d;
         found_q <= found_d;
         op_q    <= op_d;
      end
   end

endmodule

// File: rtl/alu_seq.sv
// Registered multi-cycle execute-stage ALU with issue handshake, iterative bit counting
// and a timeout-guarded trace-buffer read port.
module alu_seq
   import alu_seq_pkg::*;
#(
   parameter int unsigned XLEN        = RV_XLEN,
   parameter int unsigned CNT_STEP    = 8,
   parameter int unsigned BUF_IDX_W   = 20,
   parameter int unsigned BUF_TIMEOUT = 16
) (
   input  logic                     clk_i,
   input  logic                     rst_ni,
   input  logic                     flush_i,
   input  fu_data_t                 fu_data_i,
   input  logic [4:0]               rs1_i,
   input  logic                     alu_valid_i,
   output logic                     alu_ready_o,
   output logic                     alu_valid_o,
   output logic [TRANS_ID_BITS-1:0] alu_trans_id_o,
   output logic [XLEN-1:0]          result_o,
   output logic                     alu_branch_res_o,
   output logic                     buf_rd_req_o,
   output logic [BUF_IDX_W-1:0]     buf_rd_index_o,
   input  logic [31:0]              buf_rd_data_i,
   input  logic                     buf_rd_valid_i
);

   localparam int unsigned ShW  = $clog2(XLEN);
   localparam int unsigned CntW = $clog2(XLEN + 1);
   localparam int unsigned TmoW = $clog2(BUF_TIMEOUT + 1);

   alu_seq_state_e           state_q, state_d;
   logic                     valid_q, valid_d, branch_q, branch_d;
   logic [XLEN-1:0]          result_q, result_d;
   logic [TRANS_ID_BITS-1:0] id_q, id_d;
   logic [TmoW-1:0]          tmo_q, tmo_d;
   logic [BUF_IDX_W-1:0]     index_q, index_d;

   logic [XLEN-1:0]   opa, opb, alu_res;
   logic [2*XLEN-1:0] dbl;
   logic [63:0]       dbl_w;
   logic [ShW-1:0]    shamt;
   logic [4:0]        shamt_w;
   logic              alu_br, accept, is_iter, cnt_word, cnt_done, tmo_hit;
   cnt_op_e           cnt_op;
   logic [CntW-1:0]   cnt_count;
   logic              unused_imm;

   assign unused_imm = ^fu_data_i.imm[RV_XLEN-1:BUF_IDX_W];

   function automatic logic [XLEN-1:0] sext32(input logic [31:0] x);
      return XLEN'($signed(x));
   endfunction

   always_comb begin
      opa     = fu_data_i.operand_a[XLEN-1:0];
      opb     = fu_data_i.operand_b[XLEN-1:0];
      shamt   = opb[ShW-1:0];
      shamt_w = opb[4:0];
      alu_res = '0;
      alu_br  = 1'b1;
      dbl     = '0;
      dbl_w   = '0;
      case (fu_data_i.operation)
         ADD:  alu_res = opa + opb;
         SUB:  alu_res = opa - opb;
         ADDW: alu_res = sext32(opa[31:0] + opb[31:0]);
         SUBW: alu_res = sext32(opa[31:0] - opb[31:0]);
         XORL: alu_res = opa ^ opb;
         ORL:  alu_res = opa | opb;
         ANDL: alu_res = opa & opb;
         SLL:  alu_res = opa << shamt;
         SRL:  alu_res = opa >> shamt;
         SRA:  alu_res = $unsigned($signed(opa) >>> shamt);
         SLLW: alu_res = sext32(opa[31:0] << shamt_w);
         SRLW: alu_res = sext32(opa[31:0] >> shamt_w);
         SRAW: alu_res = sext32($unsigned($signed(opa[31:0]) >>> shamt_w));
         SLTS: alu_res = XLEN'($signed(opa) < $signed(opb));
         SLTU: alu_res = XLEN'(opa < opb);
         EQ:   begin alu_br = (opa == opb);                 alu_res = XLEN'(alu_br); end
         NE:   begin alu_br = (opa != opb);                 alu_res = XLEN'(alu_br); end
         LTS:  begin alu_br = ($signed(opa) < $signed(opb)); alu_res = XLEN'(alu_br); end
         LTU:  begin alu_br = (opa < opb);                  alu_res = XLEN'(alu_br); end
         GES:  begin alu_br = ($signed(opa) >= $signed(opb)); alu_res = XLEN'(alu_br); end
         GEU:  begin alu_br = (opa >= opb);                 alu_res = XLEN'(alu_br); end
         ROL:  begin dbl = {opa, opa} << shamt; alu_res = dbl[2*XLEN-1:XLEN]; end
         ROR:  begin dbl = {opa, opa} >> shamt; alu_res = dbl[XLEN-1:0]; end
         ROLW: begin dbl_w = {opa[31:0], opa[31:0]} << shamt_w; alu_res = sext32(dbl_w[63:32]); end
         RORW: begin dbl_w = {opa[31:0], opa[31:0]} >> shamt_w; alu_res = sext32(dbl_w[31:0]); end
         DEBUG2: begin
            alu_res[XLEN-1] = 1'b1;
            alu_res[4:0]    = rs1_i;
         end
         default: begin
            alu_res = '0;
            alu_br  = 1'b1;
         end
      endcase
   end

   always_comb begin
      is_iter  = 1'b1;
      cnt_op   = CntPop;
      cnt_word = 1'b0;
      case (fu_data_i.operation)
         CPOP:  cnt_op = CntPop;
         CPOPW: cnt_word = 1'b1;
         CLZ:   cnt_op = CntLz;
         CLZW:  begin cnt_op = CntLz; cnt_word = 1'b1; end
         CTZ:   cnt_op = CntTz;
         CTZW:  begin cnt_op = CntTz; cnt_word = 1'b1; end
         default: is_iter = 1'b0;
      endcase
   end

   assign alu_ready_o = (state_q == StIdle);
   assign accept      = alu_valid_i & alu_ready_o & ~flush_i;
   assign tmo_hit     = (tmo_q == TmoW'(BUF_TIMEOUT - 1));

   alu_bitcount #(
      .XLEN     (XLEN),
      .CNT_STEP (CNT_STEP)
   ) u_bitcount (
      .clk_i     (clk_i),
      .rst_ni    (rst_ni),
      .start_i   (accept & is_iter),
      .op_i      (cnt_op),
      .word_i    (cnt_word),
      .operand_i (opa),
      .done_o    (cnt_done),
      .count_o   (cnt_count)
   );

   always_comb begin
      state_d  = state_q;
      valid_d  = 1'b0;
      result_d = result_q;
      branch_d = branch_q;
      id_d     = id_q;
      tmo_d    = tmo_q;
      index_d  = index_q;
      unique case (state_q)
         StIdle: begin
            if (accept) begin
               id_d = fu_data_i.trans_id;
               if (is_iter) begin
                  state_d = StIter;
               end else if (fu_data_i.operation == DEBUG1) begin
                  state_d = StBufWait;
                  tmo_d   = '0;
                  index_d = fu_data_i.imm[BUF_IDX_W-1:0];
               end else begin
                  valid_d  = 1'b1;
                  result_d = alu_res;
                  branch_d = alu_br;
               end
            end
         end
         StIter: begin
            if (flush_i) begin
               state_d = StIdle;
            end else if (cnt_done) begin
               state_d  = StIdle;
               valid_d  = 1'b1;
               result_d = XLEN'(cnt_count);
               branch_d = 1'b1;
            end
         end
         StBufWait: begin
            if (flush_i) begin
               // A squashed read must still absorb its ack before the next DEBUG1 issues
               state_d = (buf_rd_valid_i || tmo_hit) ? StIdle : StDrain;
               tmo_d   = tmo_q + 1'b1;
            end else if (buf_rd_valid_i) begin
               state_d  = StIdle;
               valid_d  = 1'b1;
               result_d = XLEN'(buf_rd_data_i);
               branch_d = 1'b1;
            end else if (tmo_hit) begin
               state_d  = StIdle;
               valid_d  = 1'b1;
               result_d = BUF_TIMEOUT_ALL_ONES[XLEN-1:0];
               branch_d = 1'b1;
            end else begin
               tmo_d = tmo_q + 1'b1;
            end
         end
         StDrain: begin
            if (buf_rd_valid_i || tmo_hit) state_d = StIdle;
            else                           tmo_d   = tmo_q + 1'b1;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q  <= StIdle;
         valid_q  <= 1'b0;
         result_q <= '0;
         branch_q <= 1'b0;
         id_q     <= '0;
         tmo_q    <= '0;
         index_q  <= '0;
      end else begin
         state_q  <= state_d;
         valid_q  <= valid_d;
         result_q <= result_d;
         branch_q <= branch_d;
         id_q     <= id_d;
         tmo_q    <= tmo_d;
         index_q  <= index_d;
      end
   end

   assign alu_valid_o      = valid_q;
   assign alu_trans_id_o   = id_q;
   assign result_o         = result_q;
   assign alu_branch_res_o = branch_q;
   assign buf_rd_req_o     = (state_q == StBufWait);
   assign buf_rd_index_o   = index_q;

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq: single-cycle ops, iterative counts, trace-buffer reads,
// flush and mid-operation reset.
module tb_alu_seq;
   import alu_seq_pkg::*;

   logic                     clk = 1'b0;
   logic                     rst_ni = 1'b0;
   logic                     flush = 1'b0;
   fu_data_t                 fu;
   logic [4:0]               rs1;
   logic                     alu_valid_in = 1'b0;
   logic                     alu_ready, alu_valid_out, branch_res, buf_req;
   logic [TRANS_ID_BITS-1:0] trans_id;
   logic [63:0]              result;
   logic [19:0]              buf_index;
   logic [31:0]              buf_data;
   logic                     buf_valid = 1'b0;
   logic [7:0]               bad_op;
   int                       n_cmp = 0;
   int                       n_err = 0;

   always #5 clk = ~clk;

   alu_seq #(
      .XLEN        (64),
      .CNT_STEP    (8),
      .BUF_IDX_W   (20),
      .BUF_TIMEOUT (16)
   ) dut (
      .clk_i            (clk),
      .rst_ni           (rst_ni),
      .flush_i          (flush),
      .fu_data_i        (fu),
      .rs1_i            (rs1),
      .alu_valid_i      (alu_valid_in),
      .alu_ready_o      (alu_ready),
      .alu_valid_o      (alu_valid_out),
      .alu_trans_id_o   (trans_id),
      .result_o         (result),
      .alu_branch_res_o (branch_res),
      .buf_rd_req_o     (buf_req),
      .buf_rd_index_o   (buf_index),
      .buf_rd_data_i    (buf_data),
      .buf_rd_valid_i   (buf_valid)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input fu_op_e op, input logic [63:0] a, input logic [63:0] b,
                        input logic [63:0] imm, input logic [2:0] id);
      fu.operation = op;
      fu.operand_a = a;
      fu.operand_b = b;
      fu.imm       = imm;
      fu.trans_id  = id;
      alu_valid_in = 1'b1;
   endtask

   task automatic single(input string tag, input fu_op_e op, input logic [63:0] a,
                         input logic [63:0] b, input logic [2:0] id,
                         input logic [63:0] exp_res, input logic exp_br);
      drive(op, a, b, 64'h0, id);
      chk({tag, " ready"}, 64'(alu_ready), 64'd1);
      step();
      chk({tag, " valid"}, 64'(alu_valid_out), 64'd1);
      chk({tag, " result"}, result, exp_res);
      chk({tag, " branch"}, 64'(branch_res), 64'(exp_br));
      chk({tag, " id"}, 64'(trans_id), 64'(id));
   endtask

   task automatic iter(input string tag, input fu_op_e op, input logic [63:0] a,
                       input logic [2:0] id, input int cycles, input logic [63:0] exp_res);
      drive(op, a, 64'h0, 64'h0, id);
      step();
      alu_valid_in = 1'b0;
      for (int i = 0; i < cycles; i++) begin
         chk({tag, " busy"}, 64'({alu_ready, alu_valid_out}), 64'd0);
         step();
      end
      chk({tag, " ready"}, 64'(alu_ready), 64'd1);
      chk({tag, " valid"}, 64'(alu_valid_out), 64'd1);
      chk({tag, " result"}, result, exp_res);
      chk({tag, " id"}, 64'(trans_id), 64'(id));
   endtask

   initial begin
      fu       = '0;
      rs1      = 5'h1B;
      buf_data = 32'h0;
      bad_op   = 8'hFF;
      repeat (2) @(posedge clk);
      #1;
      chk("rst ready", 64'(alu_ready), 64'd1);
      chk("rst valid", 64'(alu_valid_out), 64'd0);
      chk("rst result", result, 64'd0);
      chk("rst branch", 64'(branch_res), 64'd0);
      chk("rst id", 64'(trans_id), 64'd0);
      chk("rst req", 64'(buf_req), 64'd0);
      rst_ni = 1'b1;
      step();

      // Back-to-back single-cycle ops, ready must never drop
      single("add", ADD, 64'd5, 64'd7, 3'd1, 64'd12, 1'b1);
      single("subw", SUBW, 64'd0, 64'd1, 3'd2, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
      single("ror", ROR, 64'd1, 64'd4, 3'd3, 64'h1000_0000_0000_0000, 1'b1);
      single("rolw", ROLW, 64'h4000_0001, 64'd1, 3'd4, 64'hFFFF_FFFF_8000_0002, 1'b1);
      single("sra", SRA, 64'h8000_0000_0000_0000, 64'd4, 3'd5, 64'hF800_0000_0000_0000, 1'b1);
      single("debug2", DEBUG2, 64'd0, 64'd0, 3'd6, 64'h8000_0000_0000_001B, 1'b1);
      single("lts", LTS, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 3'd7, 64'd1, 1'b1);
      single("eq", EQ, 64'd3, 64'd4, 3'd0, 64'd0, 1'b0);
      single("geu", GEU, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 3'd1, 64'd0, 1'b0);

      drive(ADD, 64'd9, 64'd9, 64'd0, 3'd2);
      fu.operation = fu_op_e'(bad_op);
      step();
      chk("unknown valid", 64'(alu_valid_out), 64'd1);
      chk("unknown result", result, 64'd0);
      chk("unknown branch", 64'(branch_res), 64'd1);
      alu_valid_in = 1'b0;
      step();
      chk("idle valid", 64'(alu_valid_out), 64'd0);

      // Flush wins over a same-cycle issue
      drive(ADD, 64'd1, 64'd1, 64'd0, 3'd3);
      flush = 1'b1;
      step();
      flush        = 1'b0;
      alu_valid_in = 1'b0;
      chk("flush_idle valid", 64'(alu_valid_out), 64'd0);

      iter("clz_hi", CLZ, 64'h0000_0001_0000_0000, 3'd3, 8, 64'd31);
      iter("clz_zero", CLZ, 64'd0, 3'd4, 8, 64'd64);
      iter("cpopw", CPOPW, 64'hAAAA_AAAA_FFFF_FFFF, 3'd5, 4, 64'd32);
      iter("ctz", CTZ, 64'h100, 3'd6, 8, 64'd8);
      iter("ctzw_zero", CTZW, 64'hFFFF_FFFF_0000_0000, 3'd7, 4, 64'd32);
      iter("clzw", CLZW, 64'h0000_0000_0000_8000, 3'd0, 4, 64'd16);

      // Flush during ITER: back to idle, no completion
      drive(CLZ, 64'd1, 64'd0, 64'd0, 3'd1);
      step();
      alu_valid_in = 1'b0;
      step();
      step();
      flush = 1'b1;
      step();
      flush = 1'b0;
      chk("flush_iter ready", 64'(alu_ready), 64'd1);
      for (int i = 0; i < 8; i++) begin
         chk("flush_iter valid", 64'(alu_valid_out), 64'd0);
         step();
      end

      // Trace-buffer read acked on the third request cycle
      drive(DEBUG1, 64'd0, 64'd0, 64'hFFFF_FFFF_FFF0_0012, 3'd2);
      step();
      alu_valid_in = 1'b0;
      for (int i = 0; i < 2; i++) begin
         chk("dbg1 req", 64'({buf_req, alu_ready}), 64'b10);
         chk("dbg1 index", 64'(buf_index), 64'h12);
         step();
      end
      buf_valid = 1'b1;
      buf_data  = 32'hDEAD_BEEF;
      chk("dbg1 req3", 64'(buf_req), 64'd1);
      step();
      buf_valid = 1'b0;
      chk("dbg1 valid", 64'(alu_valid_out), 64'd1);
      chk("dbg1 result", result, 64'h0000_0000_DEAD_BEEF);
      chk("dbg1 id", 64'(trans_id), 64'd2);
      chk("dbg1 req_off", 64'({buf_req, alu_ready}), 64'b01);

      // No ack: forced completion after the timeout
      drive(DEBUG1, 64'd0, 64'd0, 64'h55, 3'd3);
      step();
      alu_valid_in = 1'b0;
      for (int i = 0; i < 16; i++) begin
         chk("tmo wait", 64'({buf_req, alu_valid_out}), 64'b10);
         step();
      end
      chk("tmo valid", 64'(alu_valid_out), 64'd1);
      chk("tmo result", result, 64'hFFFF_FFFF_FFFF_FFFF);
      chk("tmo req", 64'(buf_req), 64'd0);
      chk("tmo id", 64'(trans_id), 64'd3);
      step();
      chk("tmo after", 64'({buf_req, alu_valid_out}), 64'd0);

      // Flushed read drains its late ack; the next read waits for its own
      drive(DEBUG1, 64'd0, 64'd0, 64'h21, 3'd4);
      step();
      alu_valid_in = 1'b0;
      chk("drain req1", 64'(buf_req), 64'd1);
      step();
      flush = 1'b1;
      chk("drain req2", 64'(buf_req), 64'd1);
      step();
      flush = 1'b0;
      for (int i = 0; i < 3; i++) begin
         chk("drain wait", 64'({buf_req, alu_valid_out, alu_ready}), 64'd0);
         step();
      end
      buf_valid = 1'b1;
      buf_data  = 32'h1111_1111;
      chk("drain ack", 64'({buf_req, alu_valid_out, alu_ready}), 64'd0);
      step();
      buf_valid = 1'b0;
      chk("drain done", 64'({alu_valid_out, alu_ready}), 64'b01);
      drive(DEBUG1, 64'd0, 64'd0, 64'h34, 3'd5);
      step();
      alu_valid_in = 1'b0;
      for (int i = 0; i < 3; i++) begin
         chk("second wait", 64'({buf_req, alu_valid_out}), 64'b10);
         chk("second index", 64'(buf_index), 64'h34);
         step();
      end
      buf_valid = 1'b1;
      buf_data  = 32'hCAFE_F00D;
      step();
      buf_valid = 1'b0;
      chk("second valid", 64'(alu_valid_out), 64'd1);
      chk("second result", result, 64'h0000_0000_CAFE_F00D);
      chk("second id", 64'(trans_id), 64'd5);

      // Reset asserted mid-ITER
      drive(CLZ, 64'd1, 64'd0, 64'd0, 3'd6);
      step();
      alu_valid_in = 1'b0;
      step();
      rst_ni = 1'b0;
      #1;
      chk("rst_iter ready", 64'(alu_ready), 64'd1);
      chk("rst_iter valid", 64'(alu_valid_out), 64'd0);
      chk("rst_iter result", result, 64'd0);
      chk("rst_iter id", 64'(trans_id), 64'd0);
      chk("rst_iter branch", 64'(branch_res), 64'd0);
      @(posedge clk);
      #1;
      rst_ni = 1'b1;
      step();
      chk("rst_iter post", 64'({alu_ready, alu_valid_out}), 64'b10);

      // Reset asserted mid-BUF_WAIT: request drops without a clock edge
      drive(DEBUG1, 64'd0, 64'd0, 64'h7, 3'd7);
      step();
      alu_valid_in = 1'b0;
      step();
      chk("rst_buf req_before", 64'(buf_req), 64'd1);
      rst_ni = 1'b0;
      #1;
      chk("rst_buf req", 64'(buf_req), 64'd0);
      chk("rst_buf ready", 64'(alu_ready), 64'd1);
      @(posedge clk);
      #1;
      rst_ni = 1'b1;
      step();
      chk("rst_buf post", 64'({alu_ready, alu_valid_out, buf_req}), 64'b100);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
